// File: rtl/host_chan_intr_sched.sv
// Interrupt write scheduler for the host channel.
// Per-vector request tracking (IDLE / PENDING / INFLIGHT + replay), a
// round-robin pick among pending vectors, a single Avalon command register,
// and a response tracker that bounds the number of writes awaiting response.
module host_chan_intr_sched #(
    parameter int NUM_INTR     = 4,
    parameter int MAX_INFLIGHT = 2,
    parameter int ID_W         = (NUM_INTR > 1) ? $clog2(NUM_INTR) : 1
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_INTR-1:0]                 intr_req,
    input  logic [NUM_INTR-1:0]                 intr_enable,
    output logic                                wr_write,
    output logic [ID_W-1:0]                     wr_intr_id,
    input  logic                                wr_waitrequest,
    input  logic                                wr_rsp_valid,
    input  logic [ID_W-1:0]                     wr_rsp_id,
    output logic                                busy,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight_cnt,
    output logic [15:0]                         issued_cnt,
    output logic                                err_unexpected_rsp
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {
        V_IDLE     = 2'd0,
        V_PENDING  = 2'd1,
        V_INFLIGHT = 2'd2
    } vstate_t;

    // Next vector index after v, wrapping at NUM_INTR.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        if (v == ID_W'(NUM_INTR - 1)) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    // (base + k) mod NUM_INTR for base < NUM_INTR and k < NUM_INTR.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(NUM_INTR)) begin
            sum = sum - (ID_W+1)'(NUM_INTR);
        end
        return sum[ID_W-1:0];
    endfunction

    logic                  cmd_valid_reg, cmd_valid_next;
    logic [ID_W-1:0]       cmd_id_reg, cmd_id_next;
    logic [ID_W-1:0]       rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]      inflight_reg, inflight_next;
    logic [15:0]           issued_reg, issued_next;
    logic                  err_reg, err_next;

    logic                  accept;
    logic                  rsp_ok;
    logic                  launch;
    logic                  pick_found;
    logic [ID_W-1:0]       pick_id;
    logic [ID_W-1:0]       rr_eff;
    logic [NUM_INTR-1:0]   pending_vec;
    logic [NUM_INTR-1:0]   inflight_vec;
    logic [NUM_INTR-1:0]   present_hit;
    logic [NUM_INTR-1:0]   accept_hit;
    logic [NUM_INTR-1:0]   rsp_hit;
    logic [NUM_INTR-1:0]   cand;
    logic [2*NUM_INTR-1:0] rot;

    assign accept = cmd_valid_reg && !wr_waitrequest;
    assign rsp_ok = |rsp_hit;

    for (genvar gi = 0; gi < NUM_INTR; gi++) begin : g_vec
        vstate_t st_reg, st_next;
        logic    replay_reg, replay_next;
        logic    req_ok;

        assign req_ok          = intr_req[gi] && intr_enable[gi];
        assign present_hit[gi] = cmd_valid_reg && (cmd_id_reg == ID_W'(gi));
        assign accept_hit[gi]  = present_hit[gi] && !wr_waitrequest;
        // A response only counts for a vector actually awaiting one.
        assign rsp_hit[gi]     = wr_rsp_valid && (wr_rsp_id == ID_W'(gi)) &&
                                 (st_reg == V_INFLIGHT) && (inflight_reg != '0);
        assign pending_vec[gi]  = (st_reg == V_PENDING);
        assign inflight_vec[gi] = (st_reg == V_INFLIGHT);

        // Vector state register.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                st_reg     <= V_IDLE;
                replay_reg <= 1'b0;
            end else begin
                st_reg     <= st_next;
                replay_reg <= replay_next;
            end
        end

        // Vector next-state: coalesce, issue, replay and disable handling.
        always_comb begin
            st_next     = st_reg;
            replay_next = replay_reg;
            case (st_reg)
                V_IDLE: begin
                    if (req_ok) begin
                        st_next = V_PENDING;
                    end
                end
                V_PENDING: begin
                    // A presented command must complete even if disabled.
                    if (accept_hit[gi]) begin
                        st_next = V_INFLIGHT;
                    end else if (!intr_enable[gi] && !present_hit[gi]) begin
                        st_next = V_IDLE;
                    end
                end
                V_INFLIGHT: begin
                    if (rsp_hit[gi]) begin
                        st_next     = ((replay_reg && intr_enable[gi]) || req_ok) ? V_PENDING : V_IDLE;
                        replay_next = 1'b0;
                    end else if (!intr_enable[gi]) begin
                        replay_next = 1'b0;
                    end else if (req_ok) begin
                        replay_next = 1'b1;
                    end
                end
                default: begin
                    st_next     = V_IDLE;
                    replay_next = 1'b0;
                end
            endcase
        end
    end

    // Pending, still-enabled vectors; the one being accepted now is excluded
    // so a back-to-back pick never reissues it.
    assign cand = pending_vec & intr_enable & ~accept_hit;

    // Round-robin start point, already advanced past a command accepted now.
    always_comb begin
        rr_eff = rr_ptr_reg;
        if (accept) begin
            rr_eff = wrap_inc(cmd_id_reg);
        end
    end

    // First candidate at or after rr_eff; scanning downward leaves the lowest offset.
    always_comb begin
        rot        = {cand, cand} >> rr_eff;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = NUM_INTR - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick_found = 1'b1;
                pick_id    = wrap_add(rr_eff, k);
            end
        end
    end

    // Outstanding count after this cycle's acceptance and response.
    always_comb begin
        inflight_next = inflight_reg;
        if (accept && !rsp_ok) begin
            inflight_next = inflight_reg + 1'b1;
        end else if (!accept && rsp_ok) begin
            inflight_next = inflight_reg - 1'b1;
        end
    end

    // Launch only when the new command could be accepted without exceeding the limit.
    assign launch = (!cmd_valid_reg || accept) && pick_found &&
                    (inflight_next < CNT_W'(MAX_INFLIGHT));

    // Command register, pointer, counters and sticky error next values.
    always_comb begin
        cmd_valid_next = cmd_valid_reg;
        cmd_id_next    = cmd_id_reg;
        if (launch) begin
            cmd_valid_next = 1'b1;
            cmd_id_next    = pick_id;
        end else if (accept) begin
            cmd_valid_next = 1'b0;
        end
        rr_ptr_next = rr_eff;
        issued_next = issued_reg + {15'd0, accept};
        err_next    = err_reg || (wr_rsp_valid && !rsp_ok);
    end

    // Shared scheduler state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid_reg <= 1'b0;
            cmd_id_reg    <= '0;
            rr_ptr_reg    <= '0;
            inflight_reg  <= '0;
            issued_reg    <= '0;
            err_reg       <= 1'b0;
        end else begin
            cmd_valid_reg <= cmd_valid_next;
            cmd_id_reg    <= cmd_id_next;
            rr_ptr_reg    <= rr_ptr_next;
            inflight_reg  <= inflight_next;
            issued_reg    <= issued_next;
            err_reg       <= err_next;
        end
    end

    assign wr_write           = cmd_valid_reg;
    assign wr_intr_id         = cmd_id_reg;
    assign inflight_cnt       = inflight_reg;
    assign issued_cnt         = issued_reg;
    assign err_unexpected_rsp = err_reg;
    assign busy               = |(pending_vec | inflight_vec);

endmodule

// File: tb/tb_host_chan_intr_sched.sv
// Directed bench for host_chan_intr_sched (4 vectors, up to 4 in flight).
module tb_host_chan_intr_sched;

    logic        clk;
    logic        reset_n;
    logic [3:0]  intr_req;
    logic [3:0]  intr_enable;
    logic        wr_write;
    logic [1:0]  wr_intr_id;
    logic        wr_waitrequest;
    logic        wr_rsp_valid;
    logic [1:0]  wr_rsp_id;
    logic        busy;
    logic [2:0]  inflight_cnt;
    logic [15:0] issued_cnt;
    logic        err_unexpected_rsp;

    int vecs = 0;
    int errs = 0;

    host_chan_intr_sched #(
        .NUM_INTR     (4),
        .MAX_INFLIGHT (4)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .intr_req           (intr_req),
        .intr_enable        (intr_enable),
        .wr_write           (wr_write),
        .wr_intr_id         (wr_intr_id),
        .wr_waitrequest     (wr_waitrequest),
        .wr_rsp_valid       (wr_rsp_valid),
        .wr_rsp_id          (wr_rsp_id),
        .busy               (busy),
        .inflight_cnt       (inflight_cnt),
        .issued_cnt         (issued_cnt),
        .err_unexpected_rsp (err_unexpected_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        intr_req       = 4'b0000;
        intr_enable    = 4'b1111;
        wr_waitrequest = 1'b0;
        wr_rsp_valid   = 1'b0;
        wr_rsp_id      = 2'd0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic respond(input logic [1:0] id);
        wr_rsp_valid = 1'b1;
        wr_rsp_id    = id;
        tick();
        wr_rsp_valid = 1'b0;
    endtask

    initial begin
        // ---- reset state
        do_reset();
        chk("rst_write",    32'(wr_write), 32'd0);
        chk("rst_inflight", 32'(inflight_cnt), 32'd0);
        chk("rst_issued",   32'(issued_cnt), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_err",      32'(err_unexpected_rsp), 32'd0);

        // ---- all four vectors at once: back-to-back 0,1,2,3
        intr_req = 4'b1111;
        tick();
        intr_req = 4'b0000;
        chk("b2b_pend_write", 32'(wr_write), 32'd0);
        tick();
        chk("b2b_w0", 32'(wr_write), 32'd1);
        chk("b2b_id0", 32'(wr_intr_id), 32'd0);
        tick();
        chk("b2b_id1", 32'(wr_intr_id), 32'd1);
        chk("b2b_w1", 32'(wr_write), 32'd1);
        chk("b2b_iss1", 32'(issued_cnt), 32'd1);
        tick();
        chk("b2b_id2", 32'(wr_intr_id), 32'd2);
        chk("b2b_iss2", 32'(issued_cnt), 32'd2);
        tick();
        chk("b2b_id3", 32'(wr_intr_id), 32'd3);
        chk("b2b_w3", 32'(wr_write), 32'd1);
        tick();
        chk("b2b_done_write", 32'(wr_write), 32'd0);
        chk("b2b_iss4", 32'(issued_cnt), 32'd4);
        chk("b2b_infl4", 32'(inflight_cnt), 32'd4);
        // second round only replays; nothing issues until responses
        intr_req = 4'b1111;
        tick();
        intr_req = 4'b0000;
        chk("b2b_r2_wait0", 32'(wr_write), 32'd0);
        tick();
        tick();
        chk("b2b_r2_wait2", 32'(wr_write), 32'd0);
        respond(2'd0);
        chk("b2b_r2_infl3", 32'(inflight_cnt), 32'd3);
        chk("b2b_r2_nowr", 32'(wr_write), 32'd0);
        tick();
        chk("b2b_r2_w0", 32'(wr_write), 32'd1);
        chk("b2b_r2_id0", 32'(wr_intr_id), 32'd0);
        // acceptance and response together keep the count
        respond(2'd1);
        chk("same_cyc_infl", 32'(inflight_cnt), 32'd3);
        chk("same_cyc_iss", 32'(issued_cnt), 32'd5);
        chk("same_cyc_write", 32'(wr_write), 32'd0);
        tick();
        chk("b2b_r2_id1", 32'(wr_intr_id), 32'd1);
        chk("b2b_r2_w1", 32'(wr_write), 32'd1);

        // ---- minimum latency, single vector
        do_reset();
        intr_req = 4'b0100;
        tick();
        intr_req = 4'b0000;
        chk("lat_t1_write", 32'(wr_write), 32'd0);
        chk("lat_t1_busy", 32'(busy), 32'd1);
        tick();
        chk("lat_t2_write", 32'(wr_write), 32'd1);
        chk("lat_t2_id", 32'(wr_intr_id), 32'd2);
        tick();
        chk("lat_t3_write", 32'(wr_write), 32'd0);
        chk("lat_iss", 32'(issued_cnt), 32'd1);
        chk("lat_infl", 32'(inflight_cnt), 32'd1);
        respond(2'd2);
        chk("lat_rsp_infl", 32'(inflight_cnt), 32'd0);
        chk("lat_rsp_busy", 32'(busy), 32'd0);
        chk("lat_rsp_err", 32'(err_unexpected_rsp), 32'd0);

        // ---- waitrequest hold with a new request arriving
        do_reset();
        wr_waitrequest = 1'b1;
        intr_req = 4'b0010;
        tick();
        intr_req = 4'b0000;
        tick();
        chk("wait_id1", 32'(wr_intr_id), 32'd1);
        intr_req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            intr_req = 4'b0000;
            chk("wait_hold_write", 32'(wr_write), 32'd1);
            chk("wait_hold_id", 32'(wr_intr_id), 32'd1);
        end
        chk("wait_hold_iss", 32'(issued_cnt), 32'd0);
        wr_waitrequest = 1'b0;
        tick();
        chk("wait_next_write", 32'(wr_write), 32'd1);
        chk("wait_next_id", 32'(wr_intr_id), 32'd0);
        chk("wait_next_iss", 32'(issued_cnt), 32'd1);
        tick();
        chk("wait_end_write", 32'(wr_write), 32'd0);
        chk("wait_end_infl", 32'(inflight_cnt), 32'd2);

        // ---- replay: repeated requests while in flight yield one more write
        do_reset();
        intr_req = 4'b1000;
        tick();
        intr_req = 4'b0000;
        tick();
        tick();
        chk("rep_iss1", 32'(issued_cnt), 32'd1);
        for (int i = 0; i < 3; i++) begin
            intr_req = 4'b1000;
            tick();
            intr_req = 4'b0000;
            tick();
            chk("rep_nowrite", 32'(wr_write), 32'd0);
        end
        respond(2'd3);
        chk("rep_rsp_infl", 32'(inflight_cnt), 32'd0);
        chk("rep_rsp_busy", 32'(busy), 32'd1);
        tick();
        chk("rep_write", 32'(wr_write), 32'd1);
        chk("rep_id", 32'(wr_intr_id), 32'd3);
        tick();
        tick();
        tick();
        chk("rep_after_write", 32'(wr_write), 32'd0);
        chk("rep_iss2", 32'(issued_cnt), 32'd2);
        respond(2'd3);
        chk("rep_final_busy", 32'(busy), 32'd0);

        // ---- disabled vector and unexpected response
        do_reset();
        intr_enable = 4'b1101;
        intr_req = 4'b0010;
        tick();
        intr_req = 4'b0000;
        tick();
        tick();
        chk("dis_write", 32'(wr_write), 32'd0);
        chk("dis_busy", 32'(busy), 32'd0);
        respond(2'd1);
        chk("unexp_err", 32'(err_unexpected_rsp), 32'd1);
        chk("unexp_infl", 32'(inflight_cnt), 32'd0);
        tick();
        tick();
        chk("unexp_sticky", 32'(err_unexpected_rsp), 32'd1);
        intr_enable = 4'b1111;

        // ---- disable while pending: presented one completes, other drops
        do_reset();
        wr_waitrequest = 1'b1;
        intr_req = 4'b0011;
        tick();
        intr_req = 4'b0000;
        tick();
        chk("dpend_id0", 32'(wr_intr_id), 32'd0);
        intr_enable = 4'b1100;
        tick();
        chk("dpend_hold", 32'(wr_write), 32'd1);
        intr_enable = 4'b1111;
        wr_waitrequest = 1'b0;
        tick();
        chk("dpend_write", 32'(wr_write), 32'd0);
        chk("dpend_iss", 32'(issued_cnt), 32'd1);
        tick();
        chk("dpend_nowrite", 32'(wr_write), 32'd0);

        // ---- asynchronous reset mid-waitrequest with two in flight
        do_reset();
        intr_req = 4'b0111;
        tick();
        intr_req = 4'b0000;
        tick();
        tick();
        tick();
        wr_waitrequest = 1'b1;
        tick();
        chk("arst_pre_id", 32'(wr_intr_id), 32'd2);
        chk("arst_pre_infl", 32'(inflight_cnt), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_write", 32'(wr_write), 32'd0);
        chk("arst_id", 32'(wr_intr_id), 32'd0);
        chk("arst_infl", 32'(inflight_cnt), 32'd0);
        chk("arst_iss", 32'(issued_cnt), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        wr_waitrequest = 1'b0;
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        chk("arst_post_write", 32'(wr_write), 32'd0);
        respond(2'd2);
        chk("arst_late_rsp_err", 32'(err_unexpected_rsp), 32'd1);
        chk("arst_late_rsp_infl", 32'(inflight_cnt), 32'd0);
        intr_req = 4'b0010;
        tick();
        intr_req = 4'b0000;
        tick();
        chk("arst_new_write", 32'(wr_write), 32'd1);
        chk("arst_new_id", 32'(wr_intr_id), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/host_chan_intr_sched.md
Name: host_chan_intr_sched

Overview:
Schedules AFU interrupt requests onto the host channel Avalon write port used for interrupts. Interrupt writes carry an interrupt flag and vector ID in user bits.
- Collects per-vector request pulses and coalesces duplicates.
- Arbitrates round-robin among pending vectors and issues one interrupt write at a time under Avalon waitrequest rules.
- Tracks write responses so that each vector has at most one interrupt in flight.
- Sits between the AFU's interrupt sources and the host_mem write channel, alongside the 64-bit MMIO CSR block that drives the enables.

Parameters:
NUM_INTR, 4, number of interrupt vectors (1..32)
MAX_INFLIGHT, 2, max interrupt writes awaiting response across all vectors (1..NUM_INTR)
ID_W, $clog2(NUM_INTR) floored to 1, vector ID width

Ports:
clk  in  1  host channel clock; all logic on rising edge
reset_n  in  1  asynchronous assert, active-low reset
intr_req  in  NUM_INTR  per-vector single-cycle request pulse
intr_enable  in  NUM_INTR  per-vector enable from CSR; quasi-static
wr_write  out  1  Avalon interrupt write command valid
wr_intr_id  out  ID_W  vector ID carried in the write user field
wr_waitrequest  in  1  Avalon backpressure; command accepted when wr_write && !wr_waitrequest
wr_rsp_valid  in  1  write response valid for an interrupt write
wr_rsp_id  in  ID_W  vector ID of the response
busy  out  1  any vector PENDING or INFLIGHT
inflight_cnt  out  $clog2(MAX_INFLIGHT+1)  interrupt writes awaiting response
issued_cnt  out  16  accepted interrupt writes; wraps modulo 2^16
err_unexpected_rsp  out  1  sticky: response for a vector not INFLIGHT

Behaviour:
Reset:
- reset_n low asynchronously forces all vectors IDLE, rr pointer to 0, and all outputs 0.
- Reset mid-transaction drops any presented command and all in-flight tracking. Responses arriving after reset deassertion set err_unexpected_rsp.

Per-vector state (IDLE, PENDING, INFLIGHT, plus a replay bit):
- IDLE: intr_req && intr_enable -> PENDING. A request while disabled is dropped.
- PENDING: further requests are coalesced (no extra write). When chosen by the arbiter and the command is accepted -> INFLIGHT.
- INFLIGHT: intr_req && intr_enable sets replay. A response with matching id goes to PENDING if replay (or a simultaneous request) is set, otherwise IDLE; replay is cleared.
- Disabling a PENDING vector returns it to IDLE, unless it is the command currently presented on wr_write, which must complete.
- Disabling an INFLIGHT vector clears replay; the outstanding response is still consumed normally.

Issue:
- Command register idle, at least one PENDING vector, and inflight_cnt < MAX_INFLIGHT: arbiter picks the first PENDING vector at or after the rr pointer (wrapping). It registers wr_write=1 and wr_intr_id on the next cycle.
- Minimum latency: request at cycle t to an IDLE enabled vector with everything idle -> wr_write high at t+2 (t+1 PENDING, t+2 presented).
- While wr_write && wr_waitrequest, wr_write and wr_intr_id hold stable with no re-arbitration.
- On acceptance:
  - wr_write drops the next cycle, unless another command is ready, in which case it may be presented the next cycle (back-to-back allowed).
  - rr pointer = accepted id + 1 mod NUM_INTR.
  - issued_cnt increments.
  - inflight_cnt increments.

Responses:
- wr_rsp_valid decrements inflight_cnt.
- Acceptance and response in the same cycle leave inflight_cnt unchanged.
- inflight_cnt never underflows: a response with inflight_cnt==0, or for a non-INFLIGHT id, is ignored apart from setting err_unexpected_rsp.
- wr_rsp_id >= NUM_INTR is treated as unexpected.

busy is combinational from state (no pipeline delay beyond the state registers).

Test Plan:
- Pulse intr_req[2] with all enabled, waitrequest=0 -> wr_write high exactly at t+2 with id=2 for one cycle; issued_cnt=1, inflight_cnt=1. Respond id=2 -> inflight_cnt=0, busy=0.
- Pulse intr_req=4'b1111 in one cycle, MAX_INFLIGHT=4, no responses -> accepted ids 0,1,2,3 in order, back-to-back; a second round of requests then waits until the responses return.
- Hold wr_waitrequest=1 for 5 cycles while id=1 is presented and intr_req[0] pulses -> wr_intr_id stays 1 throughout; id 0 is issued only after acceptance.
- Vector 3 INFLIGHT, pulse intr_req[3] three times, then respond id=3 -> exactly one additional write with id=3; issued_cnt advances by 1.
- intr_enable[1]=0 and pulse intr_req[1] -> no write. Response for id=1 while IDLE -> err_unexpected_rsp=1 and stays set; inflight_cnt unchanged.
- Assert reset_n low mid-waitrequest with 2 in flight -> all outputs 0 immediately (asynchronously); after release, no wr_write until a new request arrives.
